// File: rtl/alu_pkg.sv
// Shared opcode constants, FSM state type and helpers for the alu_ctrl sequencer.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  function automatic logic op_legal(input logic [2:0] op);
    return (op <= OP_XOR);
  endfunction

endpackage

// File: rtl/alu_ctrl_alu.sv
// Combinational 8-bit alu: add/sub with carry-out, bitwise logic ops, zero and illegal-op flags.
module alu_ctrl_alu
  import alu_pkg::*;
(
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic [2:0] op_i,
  output logic [7:0] result_o,
  output logic       carry_o,
  output logic       zero_o,
  output logic       err_o
);

  logic [8:0] sum;

  always_comb begin
    sum      = '0;
    result_o = '0;
    carry_o  = 1'b0;
    err_o    = 1'b0;
    case (op_i)
      OP_ADD: begin
        sum      = {1'b0, a_i} + {1'b0, b_i};
        result_o = sum[7:0];
        carry_o  = sum[8];
      end
      OP_SUB: begin
        // Borrow shows up as bit 8 of the 9-bit difference.
        sum      = {1'b0, a_i} - {1'b0, b_i};
        result_o = sum[7:0];
        carry_o  = sum[8];
      end
      OP_AND:  result_o = a_i & b_i;
      OP_OR:   result_o = a_i | b_i;
      OP_XOR:  result_o = a_i ^ b_i;
      default: err_o    = 1'b1;
    endcase
    zero_o = (result_o == '0);
  end

endmodule

// File: rtl/alu_ctrl.sv
// Command sequencer around alu_ctrl_alu with an inline register file.
// Optional immediate operand b is enabled by defining ALU_CTRL_IMM_EN.
module alu_ctrl
  import alu_pkg::*;
#(
  parameter int NREGS  = 4,
  parameter int REG_AW = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [REG_AW-1:0] cmd_rd,
  input  logic [REG_AW-1:0] cmd_rs1,
  input  logic [REG_AW-1:0] cmd_rs2,
  input  logic              cmd_wr,
`ifdef ALU_CTRL_IMM_EN
  input  logic              cmd_imm_sel,
  input  logic [7:0]        cmd_imm,
`endif
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [7:0]        rsp_result,
  output logic              rsp_carry,
  output logic              rsp_zero,
  output logic              rsp_err
);

  state_t                      state_q;
  logic [NREGS-1:0][7:0]       regs_q;
  logic [7:0]                  a_q, b_q, b_d;
  logic [2:0]                  op_q;
  logic [REG_AW-1:0]           rd_q;
  logic                        wr_q;
  logic                        rsp_valid_q;
  logic [7:0]                  rsp_result_q;
  logic                        rsp_carry_q, rsp_zero_q, rsp_err_q;

  logic [7:0]                  alu_result;
  logic                        alu_carry, alu_zero, alu_err;

  always_comb begin
    b_d = regs_q[cmd_rs2];
`ifdef ALU_CTRL_IMM_EN
    if (cmd_imm_sel) b_d = cmd_imm;
`endif
  end

  alu_ctrl_alu u_alu (
    .a_i      (a_q),
    .b_i      (b_q),
    .op_i     (op_q),
    .result_o (alu_result),
    .carry_o  (alu_carry),
    .zero_o   (alu_zero),
    .err_o    (alu_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      regs_q       <= '0;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= OP_ADD;
      rd_q         <= '0;
      wr_q         <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_carry_q  <= 1'b0;
      rsp_zero_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            a_q     <= regs_q[cmd_rs1];
            b_q     <= b_d;
            op_q    <= cmd_op;
            rd_q    <= cmd_rd;
            wr_q    <= cmd_wr;
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          rsp_result_q <= alu_result;
          rsp_carry_q  <= alu_carry;
          rsp_zero_q   <= alu_zero;
          rsp_err_q    <= alu_err;
          if (wr_q && op_legal(op_q)) regs_q[rd_q] <= alu_result;
          state_q <= ST_RESP;
        end
        ST_RESP: begin
          // Response is published one edge after the result registers load.
          if (!rsp_valid_q) begin
            rsp_valid_q <= 1'b1;
          end else if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready  = (state_q == ST_IDLE) && rst_n;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_carry  = rsp_carry_q;
  assign rsp_zero   = rsp_zero_q;
  assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_alu_ctrl.sv
// Self-checking bench for alu_ctrl: directed scenarios plus randomized commands against a behavioural model.
`timescale 1ns/1ps
module tb_alu_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_op = '0;
  logic [1:0] cmd_rd = '0, cmd_rs1 = '0, cmd_rs2 = '0;
  logic       cmd_wr = 1'b0;
`ifdef ALU_CTRL_IMM_EN
  logic       cmd_imm_sel = 1'b0;
  logic [7:0] cmd_imm = '0;
`endif
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_result;
  logic       rsp_carry, rsp_zero, rsp_err;

  alu_ctrl #(.NREGS(4), .REG_AW(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_rd     (cmd_rd),
    .cmd_rs1    (cmd_rs1),
    .cmd_rs2    (cmd_rs2),
    .cmd_wr     (cmd_wr),
`ifdef ALU_CTRL_IMM_EN
    .cmd_imm_sel(cmd_imm_sel),
    .cmd_imm    (cmd_imm),
`endif
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_carry  (rsp_carry),
    .rsp_zero   (rsp_zero),
    .rsp_err    (rsp_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
  endtask

  task automatic timeout(input string nm);
    n_chk++;
    $display("FAIL %s: no handshake within cycle budget at t=%0t", nm, $time);
  endtask

  typedef struct {
    logic [7:0] res;
    logic       c;
    logic       z;
    logic       e;
  } exp_t;

  function automatic exp_t model(input int op, input int a, input int b);
    exp_t r;
    int   v;
    r.c = 1'b0;
    r.e = 1'b0;
    v   = 0;
    case (op)
      0: begin v = a + b; r.c = (v > 255); end
      1: begin v = a - b; r.c = (v < 0);   end
      2: v = a & b;
      3: v = a | b;
      4: v = a ^ b;
      default: r.e = 1'b1;
    endcase
    r.res = v[7:0];
    r.z   = (r.res == 8'h00);
    return r;
  endfunction

  logic [7:0] m_regs [4];
  bit         busy = 1'b0;
  int         acc_cyc = 0;
  exp_t       cur;

  always @(negedge clk) begin : mon
    bit   vexp;
    int   a, b;
    if (!rst_n) begin
      chk("reset rsp_valid",  32'(rsp_valid), 0);
      chk("reset cmd_ready",  32'(cmd_ready), 0);
      chk("reset rsp_result", 32'(rsp_result), 0);
      chk("reset rsp_flags",  32'({rsp_carry, rsp_zero, rsp_err}), 0);
      busy = 1'b0;
      for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
    end else begin
      vexp = busy && (cyc >= acc_cyc + 2);
      chk("cmd_ready", 32'(cmd_ready), 32'(!busy));
      chk("rsp_valid", 32'(rsp_valid), 32'(vexp));
      if (vexp) begin
        chk("rsp_result", 32'(rsp_result), 32'(cur.res));
        chk("rsp_carry",  32'(rsp_carry),  32'(cur.c));
        chk("rsp_zero",   32'(rsp_zero),   32'(cur.z));
        chk("rsp_err",    32'(rsp_err),    32'(cur.e));
      end
      if (vexp && rsp_ready) begin
        busy = 1'b0;
      end else if (!busy && cmd_valid) begin
        a = int'(m_regs[cmd_rs1]);
        b = int'(m_regs[cmd_rs2]);
`ifdef ALU_CTRL_IMM_EN
        if (cmd_imm_sel) b = int'(cmd_imm);
`endif
        cur = model(int'(cmd_op), a, b);
        if (cmd_wr && !cur.e) m_regs[cmd_rd] = cur.res;
        busy    = 1'b1;
        acc_cyc = cyc + 1;
      end
    end
  end

  logic [7:0] last_res;
  logic       last_c, last_z, last_e;

  // Drive one command; called and returns at posedge+1ns.
  task automatic issue(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                       input logic [1:0] rs2, input logic wr, input int hold, input bit stray);
    bit acc;
    int n;
    int acc_at;
    cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_wr = wr;
    cmd_valid = 1'b1;
    rsp_ready = (hold == 0);
    acc = 1'b0; n = 0;
    while (!acc && n < 20) begin
      @(negedge clk); acc = cmd_ready;
      @(posedge clk); #1; n++;
    end
    if (!acc) begin timeout("accept"); cmd_valid = 1'b0; return; end
    acc_at = cyc;
    cmd_valid = stray;
    if (stray) begin
      cmd_op = 3'($urandom_range(0, 7)); cmd_rd = 2'($urandom_range(0, 3));
      cmd_rs1 = 2'($urandom_range(0, 3)); cmd_rs2 = 2'($urandom_range(0, 3)); cmd_wr = 1'b1;
    end
    acc = 1'b0; n = 0;
    while (!acc && n < 20) begin
      @(negedge clk); acc = rsp_valid; n++;
    end
    if (!acc) begin timeout("response"); cmd_valid = 1'b0; rsp_ready = 1'b0; return; end
    chk("latency", 32'(cyc - acc_at), 2);
    repeat (hold) begin @(posedge clk); #1; end
    rsp_ready = 1'b1;
    if (hold > 0) @(negedge clk);
    last_res = rsp_result; last_c = rsp_carry; last_z = rsp_zero; last_e = rsp_err;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
  endtask

  // Places a register value directly; must be called with the DUT idle.
  task automatic preload(input int idx, input logic [7:0] val);
    logic [3:0][7:0] v;
    m_regs[idx] = val;
    for (int i = 0; i < 4; i++) v[i] = m_regs[i];
    force dut.regs_q = v;
    @(posedge clk); #1;
    release dut.regs_q;
  endtask

  task automatic expect_rsp(input string nm, input logic [7:0] r, input logic c, input logic z, input logic e);
    chk({nm, " result"}, 32'(last_res), 32'(r));
    chk({nm, " carry"},  32'(last_c),   32'(c));
    chk({nm, " zero"},   32'(last_z),   32'(z));
    chk({nm, " err"},    32'(last_e),   32'(e));
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    issue(3'b000, 2'd0, 2'd0, 2'd0, 1'b1, 0, 1'b0);
    expect_rsp("t1 add0", 8'h00, 1'b0, 1'b1, 1'b0);

    preload(1, 8'hFF); preload(2, 8'h01);
    issue(3'b000, 2'd3, 2'd1, 2'd2, 1'b1, 1, 1'b0);
    expect_rsp("t2 addwrap", 8'h00, 1'b1, 1'b1, 1'b0);
    issue(3'b011, 2'd0, 2'd3, 2'd3, 1'b0, 0, 1'b0);
    expect_rsp("t2 r3read", 8'h00, 1'b0, 1'b1, 1'b0);

    preload(1, 8'h05); preload(2, 8'h07);
    issue(3'b001, 2'd0, 2'd1, 2'd2, 1'b0, 0, 1'b0);
    expect_rsp("t3 sub borrow", 8'hFE, 1'b1, 1'b0, 1'b0);
    issue(3'b001, 2'd0, 2'd2, 2'd2, 1'b0, 2, 1'b0);
    expect_rsp("t3 sub equal", 8'h00, 1'b0, 1'b1, 1'b0);

    preload(1, 8'h3C);
    issue(3'b110, 2'd1, 2'd2, 2'd2, 1'b1, 0, 1'b0);
    expect_rsp("t4 illegal", 8'h00, 1'b0, 1'b1, 1'b1);
    issue(3'b011, 2'd0, 2'd1, 2'd1, 1'b0, 0, 1'b0);
    expect_rsp("t4 r1kept", 8'h3C, 1'b0, 1'b0, 1'b0);

    issue(3'b000, 2'd0, 2'd1, 2'd2, 1'b0, 5, 1'b1);
    expect_rsp("t5 hold", 8'h43, 1'b0, 1'b0, 1'b0);

    for (int it = 0; it < 150; it++) begin
      if (it % 8 == 0) preload(int'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
`ifdef ALU_CTRL_IMM_EN
      cmd_imm_sel = 1'($urandom_range(0, 1));
      cmd_imm     = 8'($urandom_range(0, 255));
`endif
      issue(($urandom_range(0, 4) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4)),
            2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
    end
`ifdef ALU_CTRL_IMM_EN
    cmd_imm_sel = 1'b0;
`endif

    preload(1, 8'h5A);
    cmd_op = 3'b000; cmd_rd = 2'd2; cmd_rs1 = 2'd1; cmd_rs2 = 2'd1; cmd_wr = 1'b1;
    cmd_valid = 1'b1; rsp_ready = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("t6 async rsp_valid", 32'(rsp_valid), 0);
    chk("t6 async cmd_ready", 32'(cmd_ready), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    rsp_ready = 1'b0;
    issue(3'b011, 2'd0, 2'd2, 2'd2, 1'b0, 0, 1'b0);
    expect_rsp("t6 r2 cleared", 8'h00, 1'b0, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
